key_debounce_multi: RTL and testbench

- Parametrised N-channel successor to the single-key edge detector.
- Per channel: synchronises a raw mechanical key input and debounces it with a hold-time counter.
- Per channel outputs: a clean level, one-cycle press and release pulses, and a press-toggled status bit.
- Sits between board key pins and control logic, e.g. mode select or LED toggle.

---
 rtl/key_pkg.sv | 16 +
 rtl/key_debounce_ch.sv | 135 +++++++++++++
 rtl/key_debounce_multi.sv | 38 +++
 tb/tb_key_debounce_multi.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and sizing helper for the key debouncer
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce FSM, output registers
// Optional long-press detector enabled by KEY_LONG_PRESS_EN.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int LONG_CYC       = 50000000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_toggle,
  output logic key_long
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic          IDLE_PIN = KEY_ACTIVE_LOW;

  logic [1:0]    sync_q;
  logic          pressed;
  key_state_t    state;
  logic [CW-1:0] cnt;

  // Reset loads the idle pin level so leaving reset cannot look like an edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= {2{IDLE_PIN}};
    end else begin
      sync_q <= {sync_q[0], key};
    end
  end

  assign pressed = sync_q[1] ^ KEY_ACTIVE_LOW;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= RELEASED;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_toggle  <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        RELEASED: begin
          if (pressed) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= PRESSED;
            cnt        <= '0;
            key_level  <= 1'b1;
            key_press  <= 1'b1;
            key_toggle <= ~key_toggle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int            LW        = cnt_width(LONG_CYC);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYC - 1);

  logic [LW-1:0] long_cnt;
  logic          long_done;

  // Counter parks at its terminal value; long_done blocks a repeat pulse.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (state == PRESSED) begin
        if (long_cnt == LONG_LAST) begin
          if (!long_done) begin
            key_long  <= 1'b1;
            long_done <= 1'b1;
          end
        end else begin
          long_cnt <= long_cnt + 1'b1;
        end
      end else begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_CYC > 0);
  assign key_long        = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N independent debounced key channels
// Long-press pulses available when KEY_LONG_PRESS_EN is defined.
module key_debounce_multi
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int DEBOUNCE_CYC   = 1000000,
  parameter bit KEY_ACTIVE_LOW = 1'b1,
  parameter int LONG_CYC       = 50000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle,
  output logic [NUM_KEYS-1:0] key_long
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW),
      .LONG_CYC      (LONG_CYC)
    ) u_ch (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .key        (key[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_toggle (key_toggle[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - directed vector bench for key_debounce_multi
module tb_key_debounce_multi;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key;
  logic [3:0] key_level, key_press, key_release, key_toggle, key_long;

  int tests  = 0;
  int failed = 0;

  key_debounce_multi #(
    .NUM_KEYS      (4),
    .DEBOUNCE_CYC  (4),
    .KEY_ACTIVE_LOW(1'b1),
    .LONG_CYC      (10)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst;
    logic [3:0] key;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] tgl;
    logic [3:0] lng;
  } vec_t;

  localparam int NV = 35;
  vec_t vecs[NV];

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  task automatic step(input logic [3:0] k, input logic r);
    key     = k;
    sys_rst = r;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d] got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int n_press, n_rel, n_long, press_at, long_at;
    logic sticky;

    key     = 4'hF;
    sys_rst = 1'b1;

    // Pin edge captured at vector 3 -> press 6 later; release edge at 23 -> release at 29.
    for (int i = 0; i < NV; i++) begin
      vecs[i].rst = (i == 0);
      vecs[i].key = (i >= 3 && i < 23) ? 4'b1110 : 4'b1111;
      vecs[i].lvl = {3'b000, (i >= 9 && i < 29)};
      vecs[i].prs = {3'b000, (i == 9)};
      vecs[i].rel = {3'b000, (i == 29)};
      vecs[i].tgl = {3'b000, (i >= 9)};
      vecs[i].lng = {3'b000, (LONG_ON && i == 19)};
    end

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].key, vecs[i].rst);
      chk("v_level",   i, key_level,   vecs[i].lvl);
      chk("v_press",   i, key_press,   vecs[i].prs);
      chk("v_release", i, key_release, vecs[i].rel);
      chk("v_toggle",  i, key_toggle,  vecs[i].tgl);
      chk("v_long",    i, key_long,    vecs[i].lng);
    end

    // Second press held 30 cycles: toggle returns to 0, long fires once.
    n_press = 0; n_long = 0; press_at = -1; long_at = -1;
    for (int k = 0; k < 30; k++) begin
      step(4'b1110, 1'b0);
      if (key_press[0]) begin n_press++; press_at = k; end
      if (key_long[0])  begin n_long++;  long_at  = k; end
    end
    chk_int("p2_press_count", n_press, 1);
    chk_int("p2_press_cycle", press_at, 6);
    chk_int("p2_long_count", n_long, LONG_ON ? 1 : 0);
    chk_int("p2_long_cycle", long_at, LONG_ON ? 16 : -1);
    chk("p2_toggle", 0, key_toggle, 4'b0000);
    n_rel = 0; n_long = 0;
    for (int k = 0; k < 12; k++) begin
      step(4'b1111, 1'b0);
      chk("p2_release", k, key_release, (k == 6) ? 4'b0001 : 4'b0000);
      if (key_long[0]) n_long++;
    end
    chk_int("p2_long_after_release", n_long, 0);
    chk("p2_level_end", 0, key_level, 4'b0000);
    chk("p2_toggle_end", 0, key_toggle, 4'b0000);

    // Bounce on key[1]: 3 low, 2 high, 3 low, then high.
    sticky = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ((k < 3) || (k >= 5 && k < 8)) step(4'b1101, 1'b0);
      else                               step(4'b1111, 1'b0);
      sticky = sticky | key_press[1] | key_release[1] | key_level[1] | key_toggle[1];
    end
    chk("bounce_activity", 1, {3'b000, sticky}, 4'b0000);

    // All four keys pressed in the same cycle.
    for (int k = 0; k < 10; k++) begin
      step(4'b0000, 1'b0);
      chk("simul_press", k, key_press, (k == 6) ? 4'b1111 : 4'b0000);
    end
    chk("simul_level", 0, key_level, 4'b1111);
    for (int k = 0; k < 10; k++) begin
      step(4'b1111, 1'b0);
      chk("simul_release", k, key_release, (k == 6) ? 4'b1111 : 4'b0000);
    end
    chk("simul_toggle", 0, key_toggle, 4'b1111);

    // Reset during debounce of key[2]; the count restarts from scratch.
    for (int k = 0; k < 3; k++) step(4'b1011, 1'b0);
    step(4'b1011, 1'b1);
    chk("rst_level",   0, key_level,   4'b0000);
    chk("rst_press",   0, key_press,   4'b0000);
    chk("rst_release", 0, key_release, 4'b0000);
    chk("rst_toggle",  0, key_toggle,  4'b0000);
    chk("rst_long",    0, key_long,    4'b0000);
    for (int j = 1; j <= 10; j++) begin
      step(4'b1011, 1'b0);
      chk("rst_repress", j, key_press, (j == 7) ? 4'b0100 : 4'b0000);
    end
    chk("rst_level_end", 0, key_level, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
